// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first, optional
// parity, 1 or 2 stop bits, with a one-word holding register for back-to-back frames.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_bus,
  output logic              data_out,
  output logic              busy,
  output logic              ready,
  output logic              frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_nx;
  logic [BAUD_W-1:0]   baud_cnt, baud_nx;
  logic [BIT_W-1:0]    bit_cnt, bit_nx;
  logic                hold_full, hold_nx;
  logic [DATA_W-1:0]   shift_reg, shift_nx, hold_reg;
  logic                par_bit, par_nx;
  logic                line_nx;
  logic                bit_end, frame_end, accept, load_bus, load_hold, store_hold;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ (PARITY_ODD != 0);
  endfunction

  always_comb begin
    bit_end    = (baud_cnt == BAUD_LAST);
    frame_end  = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    accept     = enable && !hold_full;
    // A word goes straight to the shifter when idle or exactly at a frame boundary
    // with nothing held; otherwise it parks in the holding register.
    load_bus   = accept && ((state == IDLE) || frame_end);
    load_hold  = frame_end && hold_full;
    store_hold = accept && !load_bus;
  end

  always_comb begin
    state_nx = state;
    baud_nx  = (state == IDLE) ? '0 : baud_cnt + 1'b1;
    bit_nx   = bit_cnt;
    shift_nx = shift_reg;
    par_nx   = par_bit;
    hold_nx  = hold_full;
    line_nx  = 1'b1;

    if (state != IDLE && bit_end) begin
      baud_nx = '0;
      bit_nx  = '0;
      case (state)
        START:  state_nx = DATA;
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nx   = bit_cnt + 1'b1;
            shift_nx = shift_reg >> 1;
          end
        end
        PARITY: state_nx = STOP;
        STOP: begin
          if (bit_cnt == STOP_LAST) state_nx = IDLE;
          else                      bit_nx   = bit_cnt + 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end

    if (store_hold) hold_nx = 1'b1;

    if (load_bus || load_hold) begin
      state_nx = START;
      baud_nx  = '0;
      bit_nx   = '0;
      shift_nx = load_hold ? hold_reg : data_bus;
      par_nx   = parity_of(shift_nx);
      if (load_hold) hold_nx = 1'b0;
    end

    // The line is registered, so it is driven from the bit that the next state shows.
    case (state_nx)
      START:   line_nx = 1'b0;
      DATA:    line_nx = shift_nx[0];
      PARITY:  line_nx = par_nx;
      default: line_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      data_out  <= 1'b1;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_nx;
      bit_cnt   <= bit_nx;
      hold_full <= hold_nx;
      data_out  <= line_nx;
    end
  end

  always_ff @(posedge clk) begin
    shift_reg <= shift_nx;
    par_bit   <= par_nx;
    if (store_hold) hold_reg <= data_bus;
  end

  assign busy       = (state != IDLE);
  assign ready      = !hold_full;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations, each shadowed by a queue-of-line-samples
// reference model, plus table-driven frames and hand-written multi-frame/reset sequences.
module tb_uart_tx_param;

  localparam int NI = 5;

  function automatic int cfg_dw(input int g);  return (g == 3) ? 5 : 8; endfunction
  function automatic int cfg_cpb(input int g); return (g == 4) ? 2 : 4; endfunction
  function automatic int cfg_pe(input int g);  return (g == 1 || g == 2) ? 1 : 0; endfunction
  function automatic int cfg_po(input int g);  return (g == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(input int g);  return (g == 1) ? 2 : 1; endfunction

  logic       clk;
  logic       rst;
  logic       chk_on;
  logic       en    [NI];
  logic [8:0] din   [NI];
  logic       dout  [NI];
  logic       bsy   [NI];
  logic       rdy   [NI];
  logic       fdone [NI];

  int n_tests;
  int n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW  = cfg_dw(g);
    localparam int CPB = cfg_cpb(g);
    localparam int PE  = cfg_pe(g);
    localparam int PO  = cfg_po(g);
    localparam int SB  = cfg_sb(g);
    localparam int L   = CPB * (1 + DW + PE + SB);

    uart_tx_param #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
    ) u_dut (
      .clk(clk), .rst(rst), .enable(en[g]), .data_bus(din[g][DW-1:0]),
      .data_out(dout[g]), .busy(bsy[g]), .ready(rdy[g]), .frame_done(fdone[g])
    );

    // q holds the expected line level for the current cycle (q[0]) and every later one.
    logic q[$];
    logic acc_m;
    logic exp_line;

    function automatic void push_frame(input logic [8:0] w);
      logic p;
      p = (PO != 0);
      for (int i = 0; i < DW; i++) p ^= w[i];
      repeat (CPB) q.push_back(1'b0);
      for (int i = 0; i < DW; i++) repeat (CPB) q.push_back(w[i]);
      if (PE != 0) repeat (CPB) q.push_back(p);
      repeat (SB * CPB) q.push_back(1'b1);
    endfunction

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        q.delete();
      end else begin
        acc_m = en[g] && (q.size() <= L);
        if (q.size() > 0) void'(q.pop_front());
        if (acc_m) push_frame(din[g]);
      end
    end

    always @(negedge clk) begin
      if (chk_on) begin
        exp_line = (q.size() > 0) ? q[0] : 1'b1;
        check($sformatf("inst%0d data_out", g), dout[g], exp_line);
        check($sformatf("inst%0d busy", g), bsy[g], (q.size() > 0) ? 1 : 0);
        check($sformatf("inst%0d ready", g), rdy[g], (q.size() <= L) ? 1 : 0);
        check($sformatf("inst%0d frame_done", g), fdone[g],
              (q.size() == 1 || q.size() == L + 1) ? 1 : 0);
      end
    end
  end

  task automatic start_word(input int g, input logic [8:0] w);
    @(negedge clk);
    en[g]  = 1'b1;
    din[g] = w;
    @(posedge clk);
  endtask

  // Follows the line from the cycle after the accepting edge; optionally requests
  // a second word at cycle inj and keeps enable high with a different word after it.
  task automatic watch(input int g, input string name, input string bits, input int flen,
                       input int inj, input logic [8:0] w1, input logic [8:0] w2,
                       input int inj_len);
    int cpb, n, line_err, fd_err, busy_err;
    logic exp_b, exp_fd;
    cpb = cfg_cpb(g);
    n = bits.len() * cpb;
    line_err = 0; fd_err = 0; busy_err = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp_b  = (bits.substr(c / cpb, c / cpb) == "1");
      exp_fd = (((c + 1) % (flen * cpb)) == 0);
      if (dout[g] !== exp_b) line_err++;
      if (fdone[g] !== exp_fd) fd_err++;
      if (bsy[g] !== 1'b1) busy_err++;
      if (inj >= 0 && c == inj + 1) check({name, " ready after hold"}, rdy[g], 0);
      if (c == 0) begin
        en[g]  = 1'b0;
        din[g] = 9'($urandom);
      end
      if (inj >= 0) begin
        if (c == inj) begin
          en[g]  = 1'b1;
          din[g] = w1;
        end
        if (c == inj + 1) din[g] = w2;
        if (c == inj + 1 + inj_len) en[g] = 1'b0;
      end
    end
    check({name, " line cycles wrong"}, line_err, 0);
    check({name, " frame_done cycles wrong"}, fd_err, 0);
    check({name, " busy low cycles"}, busy_err, 0);
    @(negedge clk);
    check({name, " idle busy"}, bsy[g], 0);
    check({name, " idle line"}, dout[g], 1);
  endtask

  typedef struct {
    int         g;
    logic [8:0] w;
    string      bits;
    string      name;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_on  = 1'b0;
    rst     = 1'b1;
    for (int g = 0; g < NI; g++) begin
      en[g]  = 1'b0;
      din[g] = '0;
    end

    vecs[0] = '{0, 9'h0AA, "0010101011",   "8N1 0xAA"};
    vecs[1] = '{0, 9'h001, "0100000001",   "8N1 0x01"};
    vecs[2] = '{1, 9'h007, "011100000111", "8E2 0x07"};
    vecs[3] = '{1, 9'h003, "011000000011", "8E2 0x03"};
    vecs[4] = '{2, 9'h007, "01110000001",  "8O1 0x07"};
    vecs[5] = '{3, 9'h013, "0110011",      "5N1 10011"};
    vecs[6] = '{4, 9'h05A, "0010110101",   "cpb2 0x5A"};

    #1 rst = 1'b0;
    #2;
    check("reset data_out", dout[0], 1);
    check("reset busy", bsy[0], 0);
    check("reset ready", rdy[0], 1);
    check("reset frame_done", fdone[0], 0);
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      start_word(vecs[i].g, vecs[i].w);
      watch(vecs[i].g, vecs[i].name, vecs[i].bits, vecs[i].bits.len(), -1, '0, '0, 0);
    end

    // Second word while busy goes back-to-back; a third request meanwhile is dropped.
    start_word(0, 9'h0AA);
    watch(0, "b2b AA CC", {"0010101011", "0001100111"}, 10, 5, 9'h0CC, 9'h03C, 3);

    start_word(3, 9'h013);
    watch(3, "5N1 held+ignored", {"0110011", "0011101"}, 7, 3, 9'h00E, 9'h001, 4);

    // Enable held high across three words at two clocks per bit.
    start_word(4, 9'h05A);
    watch(4, "cpb2 continuous", {"0010110101", "0001111001", "0110000111"}, 10,
          0, 9'h03C, 9'h0C3, 20);

    // Reset during data bit 3 with a word parked in the holding register.
    start_word(0, 9'h00F);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) en[0] = 1'b0;
      if (c == 2) begin
        en[0]  = 1'b1;
        din[0] = 9'h081;
      end
      if (c == 3) begin
        en[0]  = 1'b0;
        din[0] = 9'h07E;
      end
    end
    check("held before reset ready", rdy[0], 0);
    #2 rst = 1'b0;
    #1;
    check("mid-frame reset data_out", dout[0], 1);
    check("mid-frame reset busy", bsy[0], 0);
    check("mid-frame reset ready", rdy[0], 1);
    check("mid-frame reset frame_done", fdone[0], 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    start_word(0, 9'h055);
    watch(0, "after reset 0x55", "0101010101", 10, -1, '0, '0, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        #3 rst = 1'b0;
        @(negedge clk);
        #3 rst = 1'b1;
      end else begin
        for (int g = 0; g < NI; g++) begin
          en[g]  = ($urandom_range(0, 3) == 0);
          din[g] = 9'($urandom);
        end
      end
    end
    for (int g = 0; g < NI; g++) en[g] = 1'b0;
    repeat (150) @(negedge clk);
    for (int g = 0; g < NI; g++) check($sformatf("inst%0d drained busy", g), bsy[g], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per serial bit, legal range >= 2.
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 inserts a parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port enable  input  1  transmit request; a word is accepted on a rising edge where enable=1 and ready=1.
REQ-009 SHALL have port data_bus  input  DATA_W  word to transmit, sampled on the accepting edge only.
REQ-010 SHALL have port data_out  output  1  registered serial line; idles high.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line.
REQ-012 SHALL have port ready  output  1  high when a new word can be accepted.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP with a one-entry holding register (hold_full flag).
REQ-015 Each line bit SHALL last exactly CLKS_PER_BIT clk cycles, timed by a baud counter running 0..CLKS_PER_BIT-1 that restarts at every bit boundary.
REQ-016 Frame order SHALL be: start (0), data LSB first (DATA_W bits), parity if PARITY_EN=1, then STOP_BITS stop bits (1).
REQ-017 Parity bit SHALL be XOR of all DATA_W data bits when PARITY_ODD=0 and its inverse when PARITY_ODD=1.
REQ-018 ready SHALL equal NOT hold_full.
REQ-019 Acceptance in IDLE SHALL load the word straight into the shift register and enter START on that same edge; data_out=0 from the next cycle, i.e. start bit begins 1 cycle after the accepting edge.
REQ-020 Acceptance while not IDLE SHALL store the word in the holding register and set hold_full.
REQ-021 At the end of the final stop bit with hold_full=1, the FSM SHALL load the held word, clear hold_full and enter START on that edge with no idle cycle between frames.
REQ-022 At the end of the final stop bit with hold_full=0 and enable=1, the word on data_bus SHALL be accepted and sent back-to-back as in REQ-021.
REQ-023 At the end of the final stop bit with hold_full=0 and enable=0, the FSM SHALL return to IDLE with data_out=1.
REQ-024 With enable=1 and ready=0, the request SHALL be ignored; the held word and data_bus value are not altered.
REQ-025 busy SHALL be 1 in every state other than IDLE and 0 in IDLE.
REQ-026 frame_done SHALL pulse for exactly one cycle per frame, including frames sent back-to-back.
REQ-027 data_bus changes after acceptance SHALL have no effect on the frame in progress or on the held word.

Reset
REQ-028 While rst=0: state=IDLE, data_out=1, busy=0, ready=1, frame_done=0, baud counter=0, bit counter=0, hold_full=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously to clk, and discard any held word.
REQ-030 After rst is released, no word SHALL be accepted before the first rising edge with rst=1.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-031 DATA_W=8, no parity, 1 stop; send 0xAA -> data_out 0,0,1,0,1,0,1,0,1,1, each bit held 4 cycles; frame_done once, 40 cycles after the start bit begins.
REQ-032 Send 0xAA, then 0xCC while busy -> ready=0 after the second accept; 0xCC start bit immediately follows the 0xAA stop bit; busy stays high across both frames; two frame_done pulses.
REQ-033 PARITY_EN=1, PARITY_ODD=0, 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; STOP_BITS=2 -> 8 high cycles before IDLE.
REQ-034 DATA_W=5, send 5'b10011 -> line 0,1,1,0,0,1,1; third request while hold_full=1 -> ignored and never transmitted.
REQ-035 rst low during data bit 3 with a held word -> data_out=1, busy=0, ready=1 immediately; after release, a new 0x55 is sent correctly and the held word never appears.
REQ-036 CLKS_PER_BIT=2, continuous enable=1 for 3 words -> three back-to-back frames of 20 cycles each with no glitch on data_out.
